// File: rtl/rv_pkg.sv
// Shared RISC-V definitions: opcodes, load funct3 encodings, writeback FSM states.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    COMMIT    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Byte/half/word extraction from an aligned load word, sign or zero extended.
module load_extend
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to funct3.
  always_comb begin
    byte_sel = word[8*offset +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LW:   value = word;
      F3_LBU:  value = {24'd0, byte_sel};
      F3_LHU:  value = {16'd0, half_sel};
      default: value = 32'd0; // reserved encodings still write, with zero data
    endcase
  end

endmodule

// File: rtl/rd_writeback.sv
// Writeback stage: selects rd data by opcode, waits for load data, drives the
// single register-file write port and publishes the pending destination.
// Optional same-cycle forwarding outputs are built when WB_BYPASS_EN is defined.
module rd_writeback
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pending_valid,
`ifdef WB_BYPASS_EN
  output logic [4:0]  pending_rd,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`else
  output logic [4:0]  pending_rd
`endif
);

  wb_state_t   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [31:0] ld_val;
  logic        accept;

  load_extend u_ext (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (mem_rdata),
    .value  (ld_val)
  );

  assign in_ready = (state_q != WAIT_LOAD);
  assign accept   = in_valid && in_ready;

  // Next-state and write-data selection; COMMIT accepts like IDLE.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    we_d    = 1'b0;
    if (state_q == WAIT_LOAD) begin
      if (mem_rvalid) begin
        wdata_d = ld_val;
        state_d = COMMIT;
        we_d    = (rd_q != 5'd0);
      end
    end else begin
      state_d = IDLE;
      if (accept) begin
        case (in_opcode)
          OP_R, OP_IMM, OP_AUIPC: begin
            wdata_d = in_alu_result;
            rd_d    = in_rd;
            state_d = COMMIT;
            we_d    = (in_rd != 5'd0);
          end
          OP_LUI: begin
            wdata_d = in_imm;
            rd_d    = in_rd;
            state_d = COMMIT;
            we_d    = (in_rd != 5'd0);
          end
          OP_JAL, OP_JALR: begin
            wdata_d = in_pc + 32'd4;
            rd_d    = in_rd;
            state_d = COMMIT;
            we_d    = (in_rd != 5'd0);
          end
          OP_LOAD: begin
            f3_d    = in_funct3;
            rd_d    = in_rd;
            off_d   = in_alu_result[1:0];
            state_d = WAIT_LOAD;
          end
          default: ; // stores, branches, unknown: nothing to write
        endcase
      end
    end
  end

  // State and write-port registers; reset discards any in-flight load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 5'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      we_q    <= we_d;
    end
  end

  assign rf_we         = we_q;
  assign rf_waddr      = rd_q;
  assign rf_wdata      = wdata_q;
  assign pending_rd    = rd_q;
  assign pending_valid = (state_q == WAIT_LOAD) ||
                         ((state_q == COMMIT) && (rd_q != 5'd0));

`ifdef WB_BYPASS_EN
  // Forward the committing write in the same cycle it reaches the register file.
  assign fwd_valid = (state_q == COMMIT) && we_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wdata_q;
`endif

endmodule

// File: tb/tb_rd_writeback.sv
// Scoreboard bench for rd_writeback: directed stimulus pushes expected writes
// (cycle, rd, data); a negedge monitor pops and compares every rf_we pulse.
module tb_rd_writeback;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result, in_imm, in_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pending_valid;
  logic [4:0]  pending_rd;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  rd_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_imm(in_imm), .in_pc(in_pc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_valid(pending_valid),
`ifdef WB_BYPASS_EN
    .pending_rd(pending_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`else
    .pending_rd(pending_rd)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_rd", {27'd0, rf_waddr}, {27'd0, e.rd});
        check("wr_data", rf_wdata, e.data);
`ifdef WB_BYPASS_EN
        check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("fwd_data", fwd_data, e.data);
`endif
      end
    end
  end

  function automatic exp_t mk(input int c, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.rd = r; e.data = d;
    return e;
  endfunction

  // Present one instruction for a single cycle (called just after a posedge).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] pc);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_rd = rd;
    in_alu_result = alu; in_imm = imm; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back(mk(cyc + 1, rd, d));
  endtask

  task automatic load(input string nm, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] addr, input logic [31:0] word,
                      input logic [31:0] exp_data);
    issue(OP_LOAD, f3, rd, addr, 32'd0, 32'd0);
    repeat (2) begin
      check({nm, "_ready_low"}, {31'd0, in_ready}, 32'd0);
      check({nm, "_pend"}, {26'd0, pending_valid, pending_rd}, {26'd0, 1'b1, rd});
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1; mem_rdata = word;
    if (rd != 5'd0) expect_write(rd, exp_data);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check({nm, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = 7'd0; in_funct3 = 3'd0; in_rd = 5'd0;
    in_alu_result = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #12;
    check("rst_outs", {rf_we, rf_waddr, pending_valid, pending_rd}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // R-type
    expect_write(5'd5, 32'h0000_00AA);
    issue(OP_R, 3'd0, 5'd5, 32'h0000_00AA, 32'd0, 32'd0);
    check("r_pend", {26'd0, pending_valid, pending_rd}, {26'd0, 1'b1, 5'd5});
    @(posedge clk); #1;
    check("idle_pend", {31'd0, pending_valid}, 32'd0);

    // Link writes, including wrap of pc+4
    expect_write(5'd1, 32'h0000_0104);
    issue(OP_JAL, 3'd0, 5'd1, 32'd0, 32'd0, 32'h0000_0100);
    expect_write(5'd2, 32'h0000_0000);
    issue(OP_JALR, 3'd0, 5'd2, 32'd0, 32'd0, 32'hFFFF_FFFC);
    expect_write(5'd3, 32'h1234_5000);
    issue(OP_LUI, 3'd0, 5'd3, 32'd0, 32'h1234_5000, 32'd0);
    expect_write(5'd4, 32'h0000_2222);
    issue(OP_AUIPC, 3'd0, 5'd4, 32'h0000_2222, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Loads with extension
    load("lb",  F3_LB,  5'd7,  32'h0000_1003, 32'h8000_0000, 32'hFFFF_FF80);
    load("lbu", F3_LBU, 5'd8,  32'h0000_1003, 32'h8000_0000, 32'h0000_0080);
    load("lh",  F3_LH,  5'd9,  32'h0000_1002, 32'h8001_0000, 32'hFFFF_8001);
    load("lhu", F3_LHU, 5'd10, 32'h0000_1000, 32'h0000_F00D, 32'h0000_F00D);
    load("lw",  F3_LW,  5'd11, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load("lres", 3'b011, 5'd12, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000);

    // No-write cases: rd=0 and store; stray mem_rvalid in IDLE
    issue(OP_LUI, 3'd0, 5'd0, 32'd0, 32'hFFFF_F000, 32'd0);
    check("x0_pend", {31'd0, pending_valid}, 32'd0);
    issue(OP_STORE, 3'd2, 5'd6, 32'h55, 32'd0, 32'd0);
    check("st_pend", {31'd0, pending_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    check("stray_ready", {31'd0, in_ready}, 32'd1);

    // Three back-to-back R-types
    expect_write(5'd13, 32'h0000_0001);
    issue(OP_R, 3'd0, 5'd13, 32'h0000_0001, 32'd0, 32'd0);
    expect_write(5'd14, 32'h0000_0002);
    issue(OP_IMM, 3'd0, 5'd14, 32'h0000_0002, 32'd0, 32'd0);
    expect_write(5'd15, 32'h0000_0003);
    issue(OP_R, 3'd0, 5'd15, 32'h0000_0003, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Reset mid-load, then a stray mem_rvalid
    issue(OP_LOAD, F3_LW, 5'd20, 32'h0, 32'd0, 32'd0);
    check("ml_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; #1;
    check("ml_rst_outs", {rf_we, rf_waddr, pending_valid, pending_rd}, 32'd0);
    check("ml_rst_wdata", rf_wdata, 32'd0);
    check("ml_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    check("ml_after_pend", {26'd0, pending_valid, pending_rd}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rd_writeback.md
# rd_writeback

Writeback stage of the RISC-V core, the write-side counterpart of the rs1 operand capture path. Accepts one retiring instruction per handshake, selects the destination value by opcode (ALU result, immediate, link address or extended load data), waits for load data when needed, and drives the single register-file write port. It also publishes the pending destination register for hazard checks.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  retiring instruction present
- in_ready  out  1  block can accept; high when state != WAIT_LOAD
- in_opcode  in  7  instruction opcode
- in_funct3  in  3  load size/sign selector
- in_rd  in  5  destination register
- in_alu_result  in  32  ALU result; the load address for loads
- in_imm  in  32  U-type immediate, already shifted
- in_pc  in  32  instruction PC
- mem_rvalid  in  1  load data valid, single-cycle pulse
- mem_rdata  in  32  aligned 32-bit load word
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write index
- rf_wdata  out  32  write data
- pending_valid  out  1  a write to pending_rd has not yet committed
- pending_rd  out  5  destination of the in-flight write

## Operation
- States: IDLE, WAIT_LOAD, COMMIT.
- An instruction is accepted when in_valid && in_ready.
- Write-data select:
  - 0110011, 0010011, 0010111 -> in_alu_result.
  - 0110111 -> in_imm.
  - 1101111, 1100111 -> in_pc + 4, modulo 2^32.
  - 0000011 -> load path.
  - 0100011, 1100011 and any other opcode -> no write.
- Writes to rd = 0 are suppressed. x0 is never written.
- Accept of a non-load writer: data and rd are registered, next state COMMIT.
- Accept of a no-write instruction: next state IDLE. No write and no pending entry.
- Accept of a load: funct3, rd and in_alu_result[1:0] are registered, next state WAIT_LOAD.
- In WAIT_LOAD, mem_rvalid triggers extraction and extension by the registered funct3 and byte offset, then next state COMMIT.
  - 000 LB: byte at offset, sign-extended.
  - 001 LH: half at offset[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extended.
  - 011, 110, 111: data = 0, the write still occurs.
- In COMMIT, rf_we = 1 for exactly that cycle, unless rd = 0. COMMIT also accepts a new instruction; its next state follows the accept rules above, otherwise IDLE.
- mem_rvalid outside WAIT_LOAD is ignored.
- pending_valid = 1 in WAIT_LOAD, and in COMMIT only when rd != 0. pending_rd is the registered rd.

## Timing
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, pending_valid 0, pending_rd 0. in_ready is 1 out of reset.
- Reset asserted mid-load returns to IDLE immediately and discards the load. A later stray mem_rvalid is ignored.
- Non-load latency: accept at edge N, rf_we high during cycle N+1.
- Load latency: mem_rvalid high in cycle M, rf_we high during cycle M+1.
- mem_rvalid arrives no earlier than the cycle after load accept.
- Throughput is one non-load write per cycle via back-to-back COMMIT.
- in_ready is low for the whole of WAIT_LOAD.
- rf_we, rf_waddr and rf_wdata are registered outputs with no combinational path from the inputs.

## Configuration
- WB_BYPASS_EN defined:
  - Adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (32).
  - These equal rf_we, rf_waddr and rf_wdata during COMMIT, so the operand stage can forward in the same cycle.
  - In WAIT_LOAD, fwd_valid is 0.
- WB_BYPASS_EN undefined: these ports and their logic are absent. Consumers stall on pending_valid until the write lands.

## Structure
- Shared package rv_pkg holds:
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR.
  - Load funct3 constants.
  - The wb_state_t enum.
- Sub-module load_extend: combinational, inputs (funct3, offset, word), output the 32-bit extended value. Reused by later load/store work.

## Test plan
- R-type, rd = 5, alu_result 0x0000_00AA -> one cycle later rf_we = 1, waddr 5, wdata 0x0000_00AA.
- JAL, pc 0x0000_0100, rd = 1 -> wdata 0x0000_0104. JALR with pc 0xFFFF_FFFC -> wdata 0x0000_0000.
- LB, offset 3, mem_rdata 0x80_00_00_00:
  - in_ready low until mem_rvalid.
  - rf_we the cycle after mem_rvalid with wdata 0xFFFF_FF80.
  - LBU, same data -> 0x0000_0080.
- LUI with rd = 0 -> rf_we never asserts and pending_valid stays 0. STORE -> no write.
- Three back-to-back R-types: rf_we high for three consecutive cycles with the correct data.
- rst asserted in WAIT_LOAD, then mem_rvalid pulsed -> all outputs at reset values and no write.
